// File: rtl/partial_sum_accum.sv
// Sums N_PASS signed ADC partials per output pixel, adds bias and optional residual, saturates, optional ReLU.
// Latency: data_out/data_out_valid register 1 clock after the final partial_valid of a pixel.
// No backpressure: a partial_valid is accepted every calculate-mode cycle, including the data_out_valid cycle.
module partial_sum_accum #(
  parameter int OUT_CH  = 64,
  parameter int ADC_W   = 6,
  parameter int ACC_W   = 20,
  parameter int N_PASS  = 4,
  parameter int OUT_PIX = 784
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          verticle_sync,
  input  logic                          mode_in,
  input  logic                          partial_valid,
  input  logic [OUT_CH-1:0][ADC_W-1:0]  adc_in,
  input  logic                          res_valid,
  input  logic [OUT_CH-1:0][15:0]       res_in,
  input  logic                          res_en,
  input  logic                          relu_en,
  input  logic                          bias_wr,
  input  logic [5:0]                    bias_addr,
  input  logic [15:0]                   bias_data,
  output logic [OUT_CH-1:0][15:0]       data_out,
  output logic                          data_out_valid,
  output logic [3:0]                    pass_cnt_o,
  output logic                          frame_done
);

  // Two guard bits over the accumulator so acc + adc + bias + residual cannot wrap.
  localparam int SUM_W = ACC_W + 2;
  localparam int PIX_W = (OUT_PIX > 1) ? $clog2(OUT_PIX) : 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(32767);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-32768);

  logic signed [ACC_W-1:0] acc [OUT_CH];
  logic signed [15:0]      bias [OUT_CH];
  logic [OUT_CH-1:0][15:0] res_q;
  logic [3:0]              pass_cnt;
  logic [PIX_W-1:0]        pix_cnt;

  logic signed [SUM_W-1:0] sum_w [OUT_CH];
  logic signed [SUM_W-1:0] res_term [OUT_CH];
  logic [OUT_CH-1:0][15:0] sat_res;

  logic clr;
  logic accept;
  logic last_pass;
  logic fin;

  // Leaving calculate mode behaves like a frame restart.
  assign clr       = verticle_sync | ~mode_in;
  assign accept    = partial_valid & ~clr;
  assign last_pass = (pass_cnt == 4'(N_PASS - 1));
  assign fin       = accept & last_pass;
  assign pass_cnt_o = pass_cnt;

  // Final-pass sum per channel, then clamp to 16 bits and optional ReLU.
  always_comb begin
    for (int c = 0; c < OUT_CH; c++) begin
      res_term[c] = res_en ? SUM_W'($signed(res_q[c])) : '0;
      sum_w[c]    = SUM_W'(acc[c]) + SUM_W'($signed(adc_in[c])) + SUM_W'(bias[c]) + res_term[c];
      if (sum_w[c] > SAT_MAX) begin
        sat_res[c] = 16'h7fff;
      end else if (sum_w[c] < SAT_MIN) begin
        sat_res[c] = 16'h8000;
      end else begin
        sat_res[c] = sum_w[c][15:0];
      end
      if (relu_en && sat_res[c][15]) begin
        sat_res[c] = '0;
      end
    end
  end

  // Pass/pixel counters and the output strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt       <= '0;
      pix_cnt        <= '0;
      data_out_valid <= 1'b0;
      frame_done     <= 1'b0;
    end else if (clr) begin
      pass_cnt       <= '0;
      pix_cnt        <= '0;
      data_out_valid <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      data_out_valid <= fin;
      frame_done     <= fin && (pix_cnt == PIX_W'(OUT_PIX - 1));
      if (accept) begin
        pass_cnt <= last_pass ? '0 : pass_cnt + 4'd1;
      end
      if (fin) begin
        pix_cnt <= (pix_cnt == PIX_W'(OUT_PIX - 1)) ? '0 : pix_cnt + PIX_W'(1);
      end
    end
  end

  // Per-channel accumulator; the final pass restarts it at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < OUT_CH; c++) acc[c] <= '0;
    end else if (clr || fin) begin
      for (int c = 0; c < OUT_CH; c++) acc[c] <= '0;
    end else if (accept) begin
      for (int c = 0; c < OUT_CH; c++) acc[c] <= acc[c] + ACC_W'($signed(adc_in[c]));
    end
  end

  // Result register; holds across clears so the last word stays observable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (fin) begin
      data_out <= sat_res;
    end
  end

  // Bias table; writable only in load mode, out-of-range addresses dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < OUT_CH; c++) bias[c] <= '0;
    end else begin
      for (int c = 0; c < OUT_CH; c++) begin
        if (!mode_in && bias_wr && (int'(bias_addr) == c)) begin
          bias[c] <= bias_data;
        end
      end
    end
  end

  // Residual capture; a same-cycle final pass still sees the previous value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
    end else if (mode_in && res_valid) begin
      res_q <= res_in;
    end
  end

endmodule

// File: tb/tb_partial_sum_accum.sv
module tb_partial_sum_accum;

  localparam int OUT_CH  = 8;
  localparam int ADC_W   = 6;
  localparam int ACC_W   = 20;
  localparam int N_PASS  = 4;
  localparam int OUT_PIX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst;
  logic                         verticle_sync;
  logic                         mode_in;
  logic                         partial_valid;
  logic [OUT_CH-1:0][ADC_W-1:0] adc_in;
  logic                         res_valid;
  logic [OUT_CH-1:0][15:0]      res_in;
  logic                         res_en;
  logic                         relu_en;
  logic                         bias_wr;
  logic [5:0]                   bias_addr;
  logic [15:0]                  bias_data;
  logic [OUT_CH-1:0][15:0]      data_out;
  logic                         data_out_valid;
  logic [3:0]                   pass_cnt_o;
  logic                         frame_done;

  partial_sum_accum #(
    .OUT_CH(OUT_CH), .ADC_W(ADC_W), .ACC_W(ACC_W), .N_PASS(N_PASS), .OUT_PIX(OUT_PIX)
  ) dut (
    .clk(clk), .rst(rst), .verticle_sync(verticle_sync), .mode_in(mode_in),
    .partial_valid(partial_valid), .adc_in(adc_in), .res_valid(res_valid), .res_in(res_in),
    .res_en(res_en), .relu_en(relu_en), .bias_wr(bias_wr), .bias_addr(bias_addr),
    .bias_data(bias_data), .data_out(data_out), .data_out_valid(data_out_valid),
    .pass_cnt_o(pass_cnt_o), .frame_done(frame_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain integers per channel.
  int m_acc  [OUT_CH];
  int m_bias [OUT_CH];
  int m_res  [OUT_CH];
  int m_dout [OUT_CH];
  int m_pass;
  int m_pix;
  bit m_vld;
  bit m_fd;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int v, input bit relu);
    int r;
    r = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
    if (relu && r < 0) r = 0;
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < OUT_CH; c++) begin
      m_acc[c] = 0; m_bias[c] = 0; m_res[c] = 0; m_dout[c] = 0;
    end
    m_pass = 0; m_pix = 0; m_vld = 0; m_fd = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_clock();
    if (rst) begin
      model_reset();
      return;
    end
    m_vld = 0;
    m_fd  = 0;
    if (verticle_sync || !mode_in) begin
      for (int c = 0; c < OUT_CH; c++) m_acc[c] = 0;
      m_pass = 0;
      m_pix  = 0;
    end else if (partial_valid) begin
      if (m_pass == N_PASS - 1) begin
        for (int c = 0; c < OUT_CH; c++) begin
          m_dout[c] = sat16(m_acc[c] + int'($signed(adc_in[c])) + m_bias[c] + (res_en ? m_res[c] : 0), relu_en);
          m_acc[c]  = 0;
        end
        m_vld  = 1;
        m_fd   = (m_pix == OUT_PIX - 1);
        m_pix  = (m_pix + 1) % OUT_PIX;
        m_pass = 0;
      end else begin
        for (int c = 0; c < OUT_CH; c++) m_acc[c] += int'($signed(adc_in[c]));
        m_pass++;
      end
    end
    if (!mode_in && bias_wr && bias_addr < OUT_CH) m_bias[bias_addr] = int'($signed(bias_data));
    if (mode_in && res_valid) begin
      for (int c = 0; c < OUT_CH; c++) m_res[c] = int'($signed(res_in[c]));
    end
  endtask

  task automatic compare_all();
    logic [OUT_CH-1:0][15:0] e;
    for (int c = 0; c < OUT_CH; c++) e[c] = 16'(m_dout[c]);
    chk("data_out", data_out, e);
    chk("data_out_valid", data_out_valid, m_vld);
    chk("frame_done", frame_done, m_fd);
    chk("pass_cnt_o", pass_cnt_o, 4'(m_pass));
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic logic [OUT_CH-1:0][ADC_W-1:0] fill(input int v);
    logic [OUT_CH-1:0][ADC_W-1:0] a;
    for (int c = 0; c < OUT_CH; c++) a[c] = ADC_W'(v);
    return a;
  endfunction

  task automatic strobe(input logic [OUT_CH-1:0][ADC_W-1:0] a);
    partial_valid = 1'b1;
    adc_in        = a;
    tick();
    partial_valid = 1'b0;
  endtask

  task automatic wbias(input int addr, input int data);
    mode_in   = 1'b0;
    bias_wr   = 1'b1;
    bias_addr = 6'(addr);
    bias_data = 16'(data);
    tick();
    bias_wr   = 1'b0;
  endtask

  logic [OUT_CH-1:0][ADC_W-1:0] a;
  int nv, nf, fd_at;

  initial begin
    rst = 1'b1; verticle_sync = 1'b0; mode_in = 1'b0; partial_valid = 1'b0;
    adc_in = '0; res_valid = 1'b0; res_in = '0; res_en = 1'b0; relu_en = 1'b0;
    bias_wr = 1'b0; bias_addr = '0; bias_data = '0;
    model_reset();
    #2;
    compare_all();
    tick();
    rst = 1'b0;

    // Basic accumulate: 10 + 5 - 3 + 7 + 2 = 21
    wbias(0, 10);
    mode_in = 1'b1;
    a = fill(0); a[0] = 6'(5);  strobe(a);
    a[0] = 6'(-3); strobe(a);
    a[0] = 6'(7);  strobe(a);
    chk("basic_no_early_vld", data_out_valid, 1'b0);
    a[0] = 6'(2);  strobe(a);
    chk("basic_dout0", data_out[0], 16'd21);
    chk("basic_vld", data_out_valid, 1'b1);
    chk("basic_pass0", pass_cnt_o, 4'd0);
    tick();
    chk("basic_vld_one_cycle", data_out_valid, 1'b0);

    // Saturation high, ReLU, saturation low
    wbias(1, 32760);
    mode_in = 1'b1;
    res_in = '0; res_in[1] = 16'd100; res_valid = 1'b1; tick(); res_valid = 1'b0;
    res_en = 1'b1;
    repeat (4) strobe(fill(31));
    chk("sat_hi", data_out[1], 16'h7fff);
    wbias(1, -32768);
    mode_in = 1'b1; relu_en = 1'b1;
    repeat (4) strobe(fill(-32));
    chk("relu_zero", data_out[1], 16'h0000);
    relu_en = 1'b0;
    repeat (4) strobe(fill(-32));
    chk("sat_lo", data_out[1], 16'h8000);

    // Residual captured in the final-pass cycle is not used until the next pixel
    res_in = '0; res_in[2] = 16'd20; res_valid = 1'b1; tick(); res_valid = 1'b0;
    repeat (3) strobe(fill(0));
    res_in[2] = 16'd50; res_valid = 1'b1;
    strobe(fill(0));
    res_valid = 1'b0;
    chk("res_old", data_out[2], 16'd20);
    repeat (4) strobe(fill(0));
    chk("res_new", data_out[2], 16'd50);

    // Mid-pixel clear
    res_en = 1'b0;
    repeat (2) strobe(fill(1));
    verticle_sync = 1'b1; tick(); verticle_sync = 1'b0;
    chk("clr_pass0", pass_cnt_o, 4'd0);
    repeat (4) strobe(fill(1));
    chk("clr_dout3", data_out[3], 16'd4);

    // Frame wrap with continuous strobes (back-to-back on valid cycles)
    verticle_sync = 1'b1; tick(); verticle_sync = 1'b0;
    nv = 0; nf = 0; fd_at = -1;
    partial_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      adc_in = fill(i % 5);
      tick();
      if (data_out_valid) nv++;
      if (frame_done) begin nf++; fd_at = i; end
    end
    partial_valid = 1'b0;
    chk("wrap_vld_cnt", nv, 5);
    chk("wrap_fd_cnt", nf, 1);
    chk("wrap_fd_at", fd_at, 15);

    // Bias protection
    mode_in = 1'b1; bias_wr = 1'b1; bias_addr = 6'd0; bias_data = 16'd999; tick(); bias_wr = 1'b0;
    wbias(40, 777);
    mode_in = 1'b1;
    repeat (4) strobe(fill(0));
    chk("bias_prot_ch0", data_out[0], 16'd10);
    chk("bias_prot_ch5", data_out[5], 16'd0);

    // Async reset mid-pixel
    repeat (2) strobe(fill(3));
    partial_valid = 1'b1; adc_in = fill(3);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_dout", data_out, '0);
    compare_all();
    partial_valid = 1'b0;
    tick();
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) begin
        res_en  = 1'($urandom_range(0, 1));
        relu_en = 1'($urandom_range(0, 1));
      end
      mode_in       = ($urandom_range(0, 19) != 0);
      verticle_sync = ($urandom_range(0, 49) == 0);
      partial_valid = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < OUT_CH; c++) begin
        adc_in[c] = ADC_W'($urandom);
        res_in[c] = 16'($urandom);
      end
      res_valid = ($urandom_range(0, 7) == 0);
      bias_wr   = ($urandom_range(0, 2) == 0);
      bias_addr = 6'($urandom_range(0, 15));
      bias_data = 16'($urandom);
      tick();
    end
    partial_valid = 1'b0; verticle_sync = 1'b0; bias_wr = 1'b0; res_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
